seq_pattern_detector: RTL
=========================

# seq_pattern_detector

Parametrised serial bit-pattern detector, the general successor to the fixed "101" Moore detector. It samples a qualified serial bit stream and recognises a runtime-loadable pattern of 1..N bits, in overlapping or non-overlapping mode. It emits a one-cycle registered match pulse and keeps a saturating match count. It sits between a serial input front end and control or status logic that reacts to framing or sync words.

## Interface
- `N`, default 8: maximum pattern length in bits (N ≥ 2).
- `CNT_W`, default 16: width of the match counter.
- `DEFAULT_PAT`, default 8'b0000_0101: pattern register reset value; low `DEFAULT_LEN` bits are used.
- `DEFAULT_LEN`, default 3: length register reset value.
- `DEFAULT_OVL`, default 1: overlap-mode reset value.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `load`  in  1  latch `pat_in`, `len_in` and `ovl_in`; clears history.
- `pat_in`  in  N  pattern; bit [len-1] is the first bit received, bit 0 the last.
- `len_in`  in  $clog2(N+1)  pattern length.
- `ovl_in`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `x_valid`  in  1  qualifies `x`; `x` is ignored when low.
- `x`  in  1  serial data bit.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `match`  out  1  one-cycle pulse: pattern completed on the previous sampled bit.
- `match_cnt`  out  CNT_W  saturating count of matches (present only with the macro).

## Operation
- State registers:
  - `hist[N-1:0]` is the shift history. On each accepted bit, `hist <= {hist[N-2:0], x}`, so the newest bit is `hist[0]`.
  - `fill` counts accepted bits since the last load, reset, or non-overlap match. It saturates at N.
  - `pat`, `len` and `ovl` are the configuration registers.
- Length rule at load: `len_in` = 0 is stored as 1; `len_in` > N is stored as N.
- Match condition, evaluated on an edge where `x_valid` = 1 and `load` = 0, using the post-shift history: `{hist[len-2:0], x} == pat[len-1:0]` and `fill + 1 ≥ len`.
- On a match:
  - `match <= 1` for exactly one cycle.
  - In overlap mode, `fill` continues to increment.
  - In non-overlap mode, `fill <= 0`. `hist` still shifts, but bits older than the match cannot contribute to a later match.
- Otherwise `match <= 0`. This includes every cycle with `x_valid` = 0; `hist` and `fill` then hold.
- `load` (priority over `x_valid`):
  - Latches the configuration.
  - Sets `fill <= 0` and `match <= 0`.
  - The bit on `x` in that cycle is discarded.
  - `hist` contents are don't-care after load, because `fill` gates them.
- Pattern bits above `len-1` are ignored.

## Timing
- Reset values:
  - `match` = 0, `match_cnt` = 0, `fill` = 0, `hist` = 0.
  - `pat` = `DEFAULT_PAT`, `len` = `DEFAULT_LEN`, `ovl` = `DEFAULT_OVL`.
- Latency: `match` is high in the cycle immediately after the rising edge that sampled the final pattern bit, i.e. 1 clock.
- Back-to-back matches: in overlap mode with a pattern of all ones or all zeros and `len` = 1, `match` stays high on consecutive cycles.
- `match_cnt` increments on the same edge that sets `match`. It holds at 2^CNT_W−1; it never wraps.
- `cnt_clr` on the same edge as a match: the clear wins and `match_cnt` = 0. The match pulse is still issued.
- `load` and `cnt_clr` together: both take effect.
- Reset asserted mid-stream: all state returns to reset values immediately, without waiting for a clock edge. The first bit after deassertion counts as bit 1.

## Configuration
- `SEQDET_COUNT_EN`
  - Defined: the `match_cnt` port, its register, saturation logic and `cnt_clr` function exist.
  - Undefined: the `match_cnt` port and counter logic are absent, `cnt_clr` is ignored (port retained), and `match` behaviour is identical.

## Test plan
- **Reset defaults.** No load; `x_valid`=1, stream 1,0,1,0,1 → `match` pulses after bits 3 and 5 (overlap). `match_cnt`=2.
- **Non-overlap with an asymmetric pattern.**
  - Setup: load `pat`=4'b1101, `len`=4, `ovl`=0.
  - Stream 1,1,0,1,1,0,1 → single match after bit 4. Bits 5–7 do not match, because `fill` was reset.
  - Stream 1,1,0,1,1,1,0,1 → matches after bits 4 and 8.
- **Valid gaps and load discard.**
  - Stream 1,0,1 with `x_valid` low for 3 cycles between each bit → one match, 1 cycle after the final valid bit.
  - `load` asserted with `x`=1, `x_valid`=1 → that bit is discarded and there is no match.
- **Length clamping.**
  - `len_in`=0, `pat`=1, overlap → stream 1,1,1 gives `match` high for 3 consecutive cycles.
  - `len_in`=N+1 → `len` is stored as N, and a match requires N valid bits.
- **Counter behaviour** (`SEQDET_COUNT_EN`, `CNT_W`=2).
  - 5 matches → `match_cnt` saturates at 3.
  - `cnt_clr` coincident with a match → `match_cnt`=0 and `match`=1.
- **Asynchronous reset mid-pattern.** After 1,0, assert `reset` between clock edges → `match`/`match_cnt` go to 0 immediately. After release, a stream of 1 alone does not match, and 1,0,1 does.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and overlap mode.
// Optional saturating match counter is built when SEQDET_COUNT_EN is defined.
module seq_pattern_detector #(
    parameter int             N           = 8,
    parameter int             CNT_W       = 16,
    parameter logic [N-1:0]   DEFAULT_PAT = 'b101,
    parameter int             DEFAULT_LEN = 3,
    parameter bit             DEFAULT_OVL = 1'b1,
    localparam int            LW          = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [N-1:0]  i_pat_in,
    input  logic [LW-1:0] i_len_in,
    input  logic          i_ovl_in,
    input  logic          i_x_valid,
    input  logic          i_x,
    input  logic          i_cnt_clr,
    output logic          o_match
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0] o_match_cnt
`endif
);

    logic [N-1:0]  r_hist;
    logic [N-1:0]  r_pat;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_fill;
    logic          r_ovl;
    logic          r_match;

    logic [N-1:0]  w_hist_next;
    logic [N-1:0]  w_mask;
    logic [LW-1:0] w_shamt;
    logic [LW:0]   w_fill_inc;
    logic [LW-1:0] w_len_clamp;
    logic          w_hit;

    assign w_hist_next = {r_hist[N-2:0], i_x};
    assign w_shamt     = LW'(N) - r_len;
    assign w_mask      = {N{1'b1}} >> w_shamt;
    assign w_fill_inc  = {1'b0, r_fill} + (LW+1)'(1);

    // The fill gate keeps stale history (after load, reset or a non-overlap hit) out of the compare.
    assign w_hit = (((w_hist_next ^ r_pat) & w_mask) == '0) && (w_fill_inc >= {1'b0, r_len});

    always_comb begin
        w_len_clamp = i_len_in;
        if (i_len_in == '0)
            w_len_clamp = LW'(1);
        else if (i_len_in > LW'(N))
            w_len_clamp = LW'(N);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist  <= '0;
            r_pat   <= DEFAULT_PAT;
            r_len   <= LW'(DEFAULT_LEN);
            r_ovl   <= DEFAULT_OVL;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (i_load) begin
            r_pat   <= i_pat_in;
            r_len   <= w_len_clamp;
            r_ovl   <= i_ovl_in;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (i_x_valid) begin
            r_hist  <= w_hist_next;
            r_match <= w_hit;
            if (w_hit && !r_ovl)
                r_fill <= '0;
            else if (r_fill != LW'(N))
                r_fill <= r_fill + LW'(1);
        end else begin
            r_match <= 1'b0;
        end
    end

    assign o_match = r_match;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             w_unused_bits;

    assign w_unused_bits = r_hist[N-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_cnt_clr)
            r_cnt <= '0;
        else if (!i_load && i_x_valid && w_hit && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_match_cnt = r_cnt;
`else
    logic [1:0] w_unused_bits;

    assign w_unused_bits = {r_hist[N-1], i_cnt_clr};
`endif

endmodule
